// File: rtl/aib_link_bringup_seq.sv
// -----------------------------------------------------------------------------
// aib_link_bringup_seq
//
// Link bring-up sequencer in front of the AIB-to-AXI bridge leader. It walks
// the bridge's AIB control inputs through adapter reset, MAC-ready and the
// DCC/DLL lock requests. It waits for far-side MAC ready and RX alignment,
// then releases the bridge's AXI-side reset and reports link_up. Losing
// far-side ready or alignment while up restarts the sequence at adapter reset.
//
// Optional feature: define AIB_BRINGUP_RETRY_EN to add parameter MAX_RETRY and
// output retry_cnt. With the feature, a wait-state timeout re-enters ADP_RST
// until MAX_RETRY retries have been used. Without it, every timeout goes to
// ERR.
//
// Ports:
//   clk_wr                  sequencer clock
//   rst_wr_n                asynchronous active-low reset
//   i_start                 level: 1 requests bring-up, 0 returns to IDLE
//   m_device_detect         far-side leader/follower detected
//   fs_mac_rdy[N]           far-side MAC ready per channel
//   m_rx_align_done[N]      RX word alignment done per channel
//   ns_adapter_rstn[N]      adapter reset to the bridge (active low)
//   ns_mac_rdy[N]           near-side MAC ready
//   ms_/sl_ rx/tx dcc_dll_lock_req[N]  leader/follower DCC/DLL lock requests
//   bridge_rst_n            AXI-side reset to the bridge
//   link_up                 link operational
//   timeout_err             sticky timeout flag, cleared on IDLE entry
//   state_o                 current state encoding (debug)
//   retry_cnt               retries used (AIB_BRINGUP_RETRY_EN only)
//
// Handshake: none. All inputs are levels sampled on every clk_wr edge. All
// outputs come from flops, so they change on the same edge as state_o.
// -----------------------------------------------------------------------------
module aib_link_bringup_seq #(
    parameter int NBR_CHNLS    = 24,
    parameter int ACTIVE_CHNLS = 1,
    parameter int RST_HOLD_CYC = 16,
    parameter int TIMEOUT_CYC  = 65535,
    parameter int CNT_W        = 16
`ifdef AIB_BRINGUP_RETRY_EN
    ,
    parameter int MAX_RETRY    = 3
`endif
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 i_start,
    input  logic                 m_device_detect,
    input  logic [NBR_CHNLS-1:0] fs_mac_rdy,
    input  logic [NBR_CHNLS-1:0] m_rx_align_done,
    output logic [NBR_CHNLS-1:0] ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0] ns_mac_rdy,
    output logic [NBR_CHNLS-1:0] ms_rx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0] ms_tx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0] sl_rx_dcc_dll_lock_req,
    output logic [NBR_CHNLS-1:0] sl_tx_dcc_dll_lock_req,
    output logic                 bridge_rst_n,
    output logic                 link_up,
    output logic                 timeout_err,
    output logic [3:0]           state_o
`ifdef AIB_BRINGUP_RETRY_EN
    ,
    output logic [3:0]           retry_cnt
`endif
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAIT_DET = 4'd1;
    localparam logic [3:0] S_ADP_RST  = 4'd2;
    localparam logic [3:0] S_MAC_RDY  = 4'd3;
    localparam logic [3:0] S_LOCK     = 4'd4;
    localparam logic [3:0] S_WAIT_FS  = 4'd5;
    localparam logic [3:0] S_WAIT_AL  = 4'd6;
    localparam logic [3:0] S_LINK_UP  = 4'd7;
    localparam logic [3:0] S_ERR      = 4'd8;

    // Ones on the driven/checked channels, zeros above them.
    localparam logic [NBR_CHNLS-1:0] ACT_MASK = ~({NBR_CHNLS{1'b1}} << ACTIVE_CHNLS);

    logic [3:0]       state;
    logic [3:0]       nxt;
    logic [3:0]       to_dest;
    logic [CNT_W-1:0] cnt;
    logic             all_fs;
    logic             all_al;
    logic             timeout;
    logic             hold_done;
    logic             ctl_on;
    logic             lock_on;

    // Inactive channels are forced to 1 so they never block the AND.
    assign all_fs    = &(fs_mac_rdy | ~ACT_MASK);
    assign all_al    = &(m_rx_align_done | ~ACT_MASK);
    assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC));
    assign hold_done = (cnt == CNT_W'(RST_HOLD_CYC - 1));

`ifdef AIB_BRINGUP_RETRY_EN
    logic [3:0] retry_q;
    logic       retry_take;

    assign to_dest = (retry_q < 4'(MAX_RETRY)) ? S_ADP_RST : S_ERR;
    // ADP_RST reached from a wait state is a retry, except for the detect
    // success path out of WAIT_DET.
    assign retry_take = (nxt == S_ADP_RST) &&
                        ((state == S_WAIT_FS) || (state == S_WAIT_AL) ||
                         ((state == S_WAIT_DET) && !m_device_detect));
    assign retry_cnt  = retry_q;
`else
    assign to_dest = S_ERR;
`endif

    // Success tests come before the timeout test so success wins a tie.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:     if (i_start) nxt = S_WAIT_DET;
            S_WAIT_DET: begin
                if (m_device_detect) nxt = S_ADP_RST;
                else if (timeout)    nxt = to_dest;
            end
            S_ADP_RST:  if (hold_done) nxt = S_MAC_RDY;
            S_MAC_RDY:  nxt = S_LOCK;
            S_LOCK:     nxt = S_WAIT_FS;
            S_WAIT_FS: begin
                if (all_fs)       nxt = S_WAIT_AL;
                else if (timeout) nxt = to_dest;
            end
            S_WAIT_AL: begin
                if (all_al)       nxt = S_LINK_UP;
                else if (timeout) nxt = to_dest;
            end
            S_LINK_UP:  if (!(all_fs && all_al)) nxt = S_ADP_RST;
            S_ERR:      nxt = S_ERR;
            default:    nxt = S_IDLE;
        endcase
        // Dropping i_start overrides every other transition.
        if (!i_start) nxt = S_IDLE;
    end

    // Output levels are decoded from the next state and registered, so they
    // line up with state_o on the entry edge.
    assign ctl_on  = (nxt == S_MAC_RDY) || (nxt == S_LOCK) || (nxt == S_WAIT_FS) ||
                     (nxt == S_WAIT_AL) || (nxt == S_LINK_UP);
    assign lock_on = (nxt == S_LOCK) || (nxt == S_WAIT_FS) ||
                     (nxt == S_WAIT_AL) || (nxt == S_LINK_UP);

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state                  <= S_IDLE;
            cnt                    <= '0;
            ns_adapter_rstn        <= '0;
            ns_mac_rdy             <= '0;
            ms_rx_dcc_dll_lock_req <= '0;
            ms_tx_dcc_dll_lock_req <= '0;
            sl_rx_dcc_dll_lock_req <= '0;
            sl_tx_dcc_dll_lock_req <= '0;
            bridge_rst_n           <= 1'b0;
            link_up                <= 1'b0;
            timeout_err            <= 1'b0;
        end else begin
            state <= nxt;
            // cnt restarts on every state change and saturates otherwise.
            if (nxt != state)      cnt <= '0;
            else if (cnt != '1)    cnt <= cnt + 1'b1;
            ns_adapter_rstn        <= ctl_on  ? ACT_MASK : '0;
            ns_mac_rdy             <= ctl_on  ? ACT_MASK : '0;
            ms_rx_dcc_dll_lock_req <= lock_on ? ACT_MASK : '0;
            ms_tx_dcc_dll_lock_req <= lock_on ? ACT_MASK : '0;
            sl_rx_dcc_dll_lock_req <= lock_on ? ACT_MASK : '0;
            sl_tx_dcc_dll_lock_req <= lock_on ? ACT_MASK : '0;
            bridge_rst_n           <= (nxt == S_LINK_UP);
            link_up                <= (nxt == S_LINK_UP);
            if (nxt == S_IDLE)     timeout_err <= 1'b0;
            else if (nxt == S_ERR) timeout_err <= 1'b1;
        end
    end

`ifdef AIB_BRINGUP_RETRY_EN
    // Retries are forgotten once the link comes up or the sequence restarts.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n)                                retry_q <= '0;
        else if ((nxt == S_IDLE) || (nxt == S_LINK_UP)) retry_q <= '0;
        else if (retry_take)                          retry_q <= retry_q + 1'b1;
    end
`endif

    assign state_o = state;

endmodule
